// File: rtl/mm_pkg.sv
// Shared types and helpers for the hardwired matrix-multiply engine.
package mm_pkg;

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, MAC, WR, DONE} state_t;

  // Widest accumulator the overflow helper can inspect.
  localparam int unsigned MAX_ACC_W = 128;

  function automatic int unsigned acc_w(input int unsigned data_w, input int unsigned dim_w);
    return 2 * data_w + dim_w;
  endfunction

  // True when the accumulator value is representable in data_w bits.
  function automatic logic fits_width(input logic [MAX_ACC_W-1:0] acc,
                                      input int unsigned          acc_width,
                                      input int unsigned          data_w,
                                      input logic                 is_signed);
    logic ok;
    ok = 1'b1;
    for (int unsigned b = 0; b < MAX_ACC_W; b++) begin
      if (b >= data_w && b < acc_width) begin
        if (is_signed ? (acc[b] != acc[data_w-1]) : acc[b]) ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/mm_addr_gen.sv
// i/j/k loop counters and A/B/D address generation; addresses reflect the
// counter values that will hold after this cycle's load/step request.
module mm_addr_gen #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DIM_W   = 8,
  parameter int unsigned NCORES  = 1,
  parameter int unsigned CORE_ID = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic              step_k,
  input  logic              step_elem,
  input  logic [DIM_W-1:0]  dim_i,
  input  logic [DIM_W-1:0]  dim_k,
  input  logic [DIM_W-1:0]  dim_j,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_d,
  output logic [ADDR_W-1:0] addr_a_c,
  output logic [ADDR_W-1:0] addr_b_c,
  output logic [ADDR_W-1:0] addr_d_c,
  output logic              last_k_c,
  output logic              last_elem_c
);

  localparam int unsigned IW = DIM_W + 1;
  localparam int unsigned PW = IW + DIM_W;

  logic [IW-1:0]     i_q, i_n, i_inc;
  logic [DIM_W-1:0]  j_q, j_n, k_q, k_n;
  logic [DIM_W-1:0]  di_q, di_n, dk_q, dk_n, dj_q, dj_n;
  logic [ADDR_W-1:0] ba_q, ba_n, bb_q, bb_n, bd_q, bd_n;
  logic [PW-1:0]     prod_ik, prod_kj, prod_ij;
  logic              last_j;

  assign i_inc       = i_q + IW'(NCORES);
  assign last_j      = (j_q == dj_q - DIM_W'(1));
  assign last_k_c    = (k_q == dk_q - DIM_W'(1));
  assign last_elem_c = last_j && (i_inc >= {1'b0, di_q});

  // Next counter values.
  always_comb begin
    i_n  = i_q;
    j_n  = j_q;
    k_n  = k_q;
    di_n = di_q;
    dk_n = dk_q;
    dj_n = dj_q;
    ba_n = ba_q;
    bb_n = bb_q;
    bd_n = bd_q;
    if (load) begin
      di_n = dim_i;
      dk_n = dim_k;
      dj_n = dim_j;
      ba_n = base_a;
      bb_n = base_b;
      bd_n = base_d;
      i_n  = IW'(CORE_ID);
      j_n  = '0;
      k_n  = '0;
    end else if (step_k) begin
      k_n = k_q + DIM_W'(1);
    end else if (step_elem) begin
      k_n = '0;
      if (last_j) begin
        j_n = '0;
        i_n = i_inc;
      end else begin
        j_n = j_q + DIM_W'(1);
      end
    end
  end

  assign prod_ik  = PW'(i_n) * PW'(dk_n);
  assign prod_kj  = PW'(k_n) * PW'(dj_n);
  assign prod_ij  = PW'(i_n) * PW'(dj_n);
  assign addr_a_c = ba_n + ADDR_W'(prod_ik) + ADDR_W'(k_n);
  assign addr_b_c = bb_n + ADDR_W'(prod_kj) + ADDR_W'(j_n);
  assign addr_d_c = bd_n + ADDR_W'(prod_ij) + ADDR_W'(j_n);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      i_q  <= '0;
      j_q  <= '0;
      k_q  <= '0;
      di_q <= '0;
      dk_q <= '0;
      dj_q <= '0;
      ba_q <= '0;
      bb_q <= '0;
      bd_q <= '0;
    end else begin
      i_q  <= i_n;
      j_q  <= j_n;
      k_q  <= k_n;
      di_q <= di_n;
      dk_q <= dk_n;
      dj_q <= dj_n;
      ba_q <= ba_n;
      bb_q <= bb_n;
      bd_q <= bd_n;
    end
  end

endmodule

// File: rtl/mm_engine.sv
// Hardwired D = A x B engine: FSM, accumulator, overflow flag and memory port.
module mm_engine
  import mm_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DIM_W   = 8,
  parameter int unsigned SIGNED  = 0,
  parameter int unsigned NCORES  = 1,
  parameter int unsigned CORE_ID = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DIM_W-1:0]  dim_i,
  input  logic [DIM_W-1:0]  dim_k,
  input  logic [DIM_W-1:0]  dim_j,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_d,
  output logic [ADDR_W-1:0] addr_data,
  output logic [DATA_W-1:0] datain,
  input  logic [DATA_W-1:0] dataout,
  output logic              write_en,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  localparam int unsigned ACC_W = acc_w(DATA_W, DIM_W);
  localparam int unsigned PW    = 2 * DATA_W;

  state_t            state, state_n;
  logic [ACC_W-1:0]  acc, acc_n, prod_ext;
  logic [DATA_W-1:0] a_reg, a_reg_n, datain_n;
  logic [ADDR_W-1:0] addr_n;
  logic              write_en_n, busy_n, done_n, ovf_n;
  logic [PW-1:0]     op_a, op_b, prod;
  logic              ag_load, ag_step_k, ag_step_elem;
  logic [ADDR_W-1:0] ag_addr_a, ag_addr_b, ag_addr_d;
  logic              ag_last_k, ag_last_elem;
  logic              empty_op;

  mm_addr_gen #(
    .ADDR_W  (ADDR_W),
    .DIM_W   (DIM_W),
    .NCORES  (NCORES),
    .CORE_ID (CORE_ID)
  ) u_addr_gen (
    .clock       (clock),
    .reset_n     (reset_n),
    .load        (ag_load),
    .step_k      (ag_step_k),
    .step_elem   (ag_step_elem),
    .dim_i       (dim_i),
    .dim_k       (dim_k),
    .dim_j       (dim_j),
    .base_a      (base_a),
    .base_b      (base_b),
    .base_d      (base_d),
    .addr_a_c    (ag_addr_a),
    .addr_b_c    (ag_addr_b),
    .addr_d_c    (ag_addr_d),
    .last_k_c    (ag_last_k),
    .last_elem_c (ag_last_elem)
  );

  // Operands are widened first so the low 2*DATA_W product bits are exact.
  always_comb begin
    if (SIGNED != 0) begin
      op_a = {{DATA_W{a_reg[DATA_W-1]}}, a_reg};
      op_b = {{DATA_W{dataout[DATA_W-1]}}, dataout};
    end else begin
      op_a = {{DATA_W{1'b0}}, a_reg};
      op_b = {{DATA_W{1'b0}}, dataout};
    end
  end

  assign prod     = op_a * op_b;
  assign prod_ext = (SIGNED != 0) ? {{DIM_W{prod[PW-1]}}, prod} : {{DIM_W{1'b0}}, prod};
  assign empty_op = (dim_i == '0) || (dim_k == '0) || (dim_j == '0) || (32'(dim_i) <= CORE_ID);

  // Next state and next registered outputs.
  always_comb begin
    state_n      = state;
    addr_n       = addr_data;
    datain_n     = datain;
    write_en_n   = 1'b0;
    busy_n       = 1'b0;
    done_n       = 1'b0;
    ovf_n        = ovf;
    acc_n        = acc;
    a_reg_n      = a_reg;
    ag_load      = 1'b0;
    ag_step_k    = 1'b0;
    ag_step_elem = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          ag_load = 1'b1;
          ovf_n   = 1'b0;
          acc_n   = '0;
          if (empty_op) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n = RD_A;
            busy_n  = 1'b1;
            addr_n  = ag_addr_a;
          end
        end
      end
      RD_A: begin
        state_n = RD_B;
        busy_n  = 1'b1;
        addr_n  = ag_addr_b;
      end
      RD_B: begin
        state_n = MAC;
        busy_n  = 1'b1;
        a_reg_n = dataout;
      end
      MAC: begin
        busy_n = 1'b1;
        acc_n  = acc + prod_ext;
        if (ag_last_k) begin
          state_n    = WR;
          addr_n     = ag_addr_d;
          datain_n   = acc_n[DATA_W-1:0];
          write_en_n = 1'b1;
          if (!fits_width(MAX_ACC_W'(acc_n), ACC_W, DATA_W, SIGNED != 0)) ovf_n = 1'b1;
        end else begin
          state_n   = RD_A;
          ag_step_k = 1'b1;
          addr_n    = ag_addr_a;
        end
      end
      WR: begin
        acc_n        = '0;
        ag_step_elem = 1'b1;
        if (ag_last_elem) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else begin
          state_n = RD_A;
          busy_n  = 1'b1;
          addr_n  = ag_addr_a;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      addr_data <= '0;
      datain    <= '0;
      write_en  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      acc       <= '0;
      a_reg     <= '0;
    end else begin
      state     <= state_n;
      addr_data <= addr_n;
      datain    <= datain_n;
      write_en  <= write_en_n;
      busy      <= busy_n;
      done      <= done_n;
      ovf       <= ovf_n;
      acc       <= acc_n;
      a_reg     <= a_reg_n;
    end
  end

endmodule

// File: tb/tb_mm_engine.sv
// Self-checking bench for mm_engine: unsigned, signed and interleaved instances.
module tb_mm_engine;

  localparam int MAX_CYC = 3000;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  // Instance 0: defaults (16-bit unsigned, single core)
  logic        start0 = 1'b0;
  logic [7:0]  di0 = '0, dk0 = '0, dj0 = '0, ba0 = '0, bb0 = '0, bd0 = '0, addr0;
  logic [15:0] din0, dout0 = '0;
  logic        we0, busy0, done0, ovf0;
  logic [15:0] mem0 [256];
  int          wr0 = 0;

  // Instance s: 8-bit signed
  logic        start_s = 1'b0;
  logic [7:0]  di_s = '0, dk_s = '0, dj_s = '0, ba_s = '0, bb_s = '0, bd_s = '0, addr_s;
  logic [7:0]  din_s, dout_s = '0;
  logic        we_s, busy_s, done_s, ovf_s;
  logic [7:0]  mem_s [256];
  int          wr_s = 0;

  // Instance m: second of two interleaved cores
  logic        start_m = 1'b0;
  logic [7:0]  di_m = '0, dk_m = '0, dj_m = '0, ba_m = '0, bb_m = '0, bd_m = '0, addr_m;
  logic [15:0] din_m, dout_m = '0;
  logic        we_m, busy_m, done_m, ovf_m;
  logic [15:0] mem_m [256];
  int          wr_m = 0;

  mm_engine u_dut0 (
    .clock(clock), .reset_n(reset_n), .start(start0), .dim_i(di0), .dim_k(dk0), .dim_j(dj0),
    .base_a(ba0), .base_b(bb0), .base_d(bd0), .addr_data(addr0), .datain(din0),
    .dataout(dout0), .write_en(we0), .busy(busy0), .done(done0), .ovf(ovf0)
  );

  mm_engine #(.DATA_W(8), .SIGNED(1)) u_dut_s (
    .clock(clock), .reset_n(reset_n), .start(start_s), .dim_i(di_s), .dim_k(dk_s), .dim_j(dj_s),
    .base_a(ba_s), .base_b(bb_s), .base_d(bd_s), .addr_data(addr_s), .datain(din_s),
    .dataout(dout_s), .write_en(we_s), .busy(busy_s), .done(done_s), .ovf(ovf_s)
  );

  mm_engine #(.NCORES(2), .CORE_ID(1)) u_dut_m (
    .clock(clock), .reset_n(reset_n), .start(start_m), .dim_i(di_m), .dim_k(dk_m), .dim_j(dj_m),
    .base_a(ba_m), .base_b(bb_m), .base_d(bd_m), .addr_data(addr_m), .datain(din_m),
    .dataout(dout_m), .write_en(we_m), .busy(busy_m), .done(done_m), .ovf(ovf_m)
  );

  // Synchronous memories: read data is valid the cycle after the address.
  always @(posedge clock) begin
    dout0  <= mem0[addr0];
    dout_s <= mem_s[addr_s];
    dout_m <= mem_m[addr_m];
    if (we0) begin mem0[addr0] = din0; wr0++; end
    if (we_s) begin mem_s[addr_s] = din_s; wr_s++; end
    if (we_m) begin mem_m[addr_m] = din_m; wr_m++; end
  end

  task automatic op0(input logic [7:0] di, dk, dj, ba, bb, bd, output int done_cyc, output int busy_cyc);
    int cyc;
    di0 = di; dk0 = dk; dj0 = dj; ba0 = ba; bb0 = bb; bd0 = bd;
    @(negedge clock); start0 = 1'b1;
    @(negedge clock); start0 = 1'b0;
    cyc = 1; busy_cyc = 0; done_cyc = -1;
    while (cyc < MAX_CYC) begin
      if (busy0) busy_cyc++;
      if (done0) begin done_cyc = cyc; break; end
      @(negedge clock); cyc++;
    end
  endtask

  task automatic op_s(input logic [7:0] di, dk, dj, ba, bb, bd, output int done_cyc, output logic ovf_at1);
    int cyc;
    di_s = di; dk_s = dk; dj_s = dj; ba_s = ba; bb_s = bb; bd_s = bd;
    @(negedge clock); start_s = 1'b1;
    @(negedge clock); start_s = 1'b0;
    cyc = 1; done_cyc = -1; ovf_at1 = ovf_s;
    while (cyc < MAX_CYC) begin
      if (done_s) begin done_cyc = cyc; break; end
      @(negedge clock); cyc++;
    end
  endtask

  task automatic op_m(input logic [7:0] di, dk, dj, ba, bb, bd, output int done_cyc, output int busy_cyc);
    int cyc;
    di_m = di; dk_m = dk; dj_m = dj; ba_m = ba; bb_m = bb; bd_m = bd;
    @(negedge clock); start_m = 1'b1;
    @(negedge clock); start_m = 1'b0;
    cyc = 1; busy_cyc = 0; done_cyc = -1;
    while (cyc < MAX_CYC) begin
      if (busy_m) busy_cyc++;
      if (done_m) begin done_cyc = cyc; break; end
      @(negedge clock); cyc++;
    end
  endtask

  task automatic load_basic();
    for (int x = 0; x < 4; x++) begin
      mem0[x]      = 16'(x + 1);
      mem0[16 + x] = 16'(x + 5);
      mem0[32 + x] = 16'h0000;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({addr0, din0, we0, busy0, done0, ovf0} !== '0) begin
      failures++; $display("FAIL reset_dut0 got %h want 0", {addr0, din0, we0, busy0, done0, ovf0});
    end
    checks++;
    if ({addr_s, din_s, we_s, busy_s, done_s, ovf_s} !== '0) begin
      failures++; $display("FAIL reset_dut_s got %h want 0", {addr_s, din_s, we_s, busy_s, done_s, ovf_s});
    end
    checks++;
    if ({addr_m, din_m, we_m, busy_m, done_m, ovf_m} !== '0) begin
      failures++; $display("FAIL reset_dut_m got %h want 0", {addr_m, din_m, we_m, busy_m, done_m, ovf_m});
    end
  endtask

  task automatic check_basic_d(input string tag);
    int exp_d [4] = '{19, 22, 43, 50};
    for (int e = 0; e < 4; e++) begin
      checks++;
      if (mem0[32 + e] !== 16'(exp_d[e])) begin
        failures++; $display("FAIL %s_d%0d got %0d want %0d", tag, e, mem0[32 + e], exp_d[e]);
      end
    end
  endtask

  task automatic test_basic();
    int dc, bc, w0;
    load_basic();
    w0 = wr0;
    op0(8'd2, 8'd2, 8'd2, 8'h00, 8'h10, 8'h20, dc, bc);
    check_basic_d("basic");
    checks++; if (dc !== 29) begin failures++; $display("FAIL basic_done_cycle got %0d want 29", dc); end
    checks++; if (bc !== 28) begin failures++; $display("FAIL basic_busy_cycles got %0d want 28", bc); end
    checks++; if (ovf0 !== 1'b0) begin failures++; $display("FAIL basic_ovf got %b want 0", ovf0); end
    checks++; if (wr0 - w0 !== 4) begin failures++; $display("FAIL basic_writes got %0d want 4", wr0 - w0); end
  endtask

  task automatic test_back_to_back();
    int dc, bc;
    load_basic();
    fork
      op0(8'd2, 8'd2, 8'd2, 8'h00, 8'h10, 8'h20, dc, bc);
      begin
        repeat (10) @(negedge clock);
        start0 = 1'b1;
        @(negedge clock); start0 = 1'b0;
        repeat (8) @(negedge clock);
        start0 = 1'b1;
        @(negedge clock); start0 = 1'b0;
      end
    join
    check_basic_d("ignored_start");
    checks++; if (dc !== 29) begin failures++; $display("FAIL ignored_start_done got %0d want 29", dc); end
    // Restart immediately from the IDLE cycle following DONE.
    for (int e = 0; e < 4; e++) mem0[32 + e] = 16'h0000;
    op0(8'd2, 8'd2, 8'd2, 8'h00, 8'h10, 8'h20, dc, bc);
    check_basic_d("b2b");
    checks++; if (dc !== 29) begin failures++; $display("FAIL b2b_done got %0d want 29", dc); end
  endtask

  task automatic test_empty();
    int dc, bc, w0;
    w0 = wr0;
    op0(8'd2, 8'd0, 8'd2, 8'h00, 8'h10, 8'h20, dc, bc);
    checks++; if (dc !== 1) begin failures++; $display("FAIL empty_done got %0d want 1", dc); end
    checks++; if (bc !== 0) begin failures++; $display("FAIL empty_busy got %0d want 0", bc); end
    checks++; if (wr0 - w0 !== 0) begin failures++; $display("FAIL empty_writes got %0d want 0", wr0 - w0); end
    w0 = wr_m;
    op_m(8'd1, 8'd1, 8'd1, 8'h00, 8'h10, 8'h20, dc, bc);
    checks++; if (dc !== 1) begin failures++; $display("FAIL coreid_empty_done got %0d want 1", dc); end
    checks++; if (wr_m - w0 !== 0) begin failures++; $display("FAIL coreid_empty_writes got %0d want 0", wr_m - w0); end
  endtask

  task automatic test_signed();
    int dc;
    logic o1;
    mem_s[0] = 8'hFD; mem_s[16] = 8'd5; mem_s[32] = 8'h00;
    op_s(8'd1, 8'd1, 8'd1, 8'h00, 8'h10, 8'h20, dc, o1);
    checks++; if (mem_s[32] !== 8'hF1) begin failures++; $display("FAIL signed_neg got %h want f1", mem_s[32]); end
    checks++; if (ovf_s !== 1'b0) begin failures++; $display("FAIL signed_neg_ovf got %b want 0", ovf_s); end
    checks++; if (dc !== 5) begin failures++; $display("FAIL signed_done got %0d want 5", dc); end
    mem_s[0] = 8'd100; mem_s[16] = 8'd100;
    op_s(8'd1, 8'd1, 8'd1, 8'h00, 8'h10, 8'h20, dc, o1);
    checks++; if (mem_s[32] !== 8'h10) begin failures++; $display("FAIL signed_big got %h want 10", mem_s[32]); end
    checks++; if (ovf_s !== 1'b1) begin failures++; $display("FAIL signed_big_ovf got %b want 1", ovf_s); end
    mem_s[0] = 8'hFD; mem_s[16] = 8'd5;
    op_s(8'd1, 8'd1, 8'd1, 8'h00, 8'h10, 8'h20, dc, o1);
    checks++; if (o1 !== 1'b0) begin failures++; $display("FAIL ovf_cleared_on_start got %b want 0", o1); end
  endtask

  task automatic test_interleave();
    int dc, bc, w0;
    mem_m[0] = 16'd2; mem_m[1] = 16'd3; mem_m[2] = 16'd4; mem_m[16] = 16'd10;
    for (int x = 0; x < 3; x++) mem_m[32 + x] = 16'hDEAD;
    w0 = wr_m;
    op_m(8'd3, 8'd1, 8'd1, 8'h00, 8'h10, 8'h20, dc, bc);
    checks++; if (mem_m[33] !== 16'd30) begin failures++; $display("FAIL ilv_row1 got %0d want 30", mem_m[33]); end
    checks++; if (mem_m[32] !== 16'hDEAD) begin failures++; $display("FAIL ilv_row0 got %h want dead", mem_m[32]); end
    checks++; if (mem_m[34] !== 16'hDEAD) begin failures++; $display("FAIL ilv_row2 got %h want dead", mem_m[34]); end
    checks++; if (wr_m - w0 !== 1) begin failures++; $display("FAIL ilv_writes got %0d want 1", wr_m - w0); end
    checks++; if (dc !== 5) begin failures++; $display("FAIL ilv_done got %0d want 5", dc); end
  endtask

  task automatic test_reset_midop();
    int dc, bc;
    load_basic();
    di0 = 8'd2; dk0 = 8'd2; dj0 = 8'd2; ba0 = 8'h00; bb0 = 8'h10; bd0 = 8'h20;
    @(negedge clock); start0 = 1'b1;
    @(negedge clock); start0 = 1'b0;
    repeat (9) @(negedge clock);
    checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL midop_busy_before got %b want 1", busy0); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({we0, busy0, done0, addr0} !== '0) begin
      failures++; $display("FAIL midop_async_clear got %h want 0", {we0, busy0, done0, addr0});
    end
    @(negedge clock); reset_n = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({we0, busy0, done0} !== 3'b000) begin
      failures++; $display("FAIL midop_idle_after got %b want 000", {we0, busy0, done0});
    end
    for (int e = 0; e < 4; e++) mem0[32 + e] = 16'h0000;
    op0(8'd2, 8'd2, 8'd2, 8'h00, 8'h10, 8'h20, dc, bc);
    check_basic_d("after_reset");
    checks++; if (dc !== 29) begin failures++; $display("FAIL after_reset_done got %0d want 29", dc); end
  endtask

  task automatic test_addr_wrap();
    int dc, bc;
    mem0[16] = 16'd1;
    for (int x = 0; x < 3; x++) mem0[48 + x] = 16'd1;
    mem0[254] = 16'hAAAA; mem0[255] = 16'hAAAA; mem0[0] = 16'hAAAA;
    op0(8'd1, 8'd1, 8'd3, 8'h10, 8'h30, 8'hFE, dc, bc);
    checks++; if (mem0[254] !== 16'd1) begin failures++; $display("FAIL wrap_fe got %h want 1", mem0[254]); end
    checks++; if (mem0[255] !== 16'd1) begin failures++; $display("FAIL wrap_ff got %h want 1", mem0[255]); end
    checks++; if (mem0[0] !== 16'd1) begin failures++; $display("FAIL wrap_00 got %h want 1", mem0[0]); end
    checks++; if (dc !== 13) begin failures++; $display("FAIL wrap_done got %0d want 13", dc); end
  endtask

  task automatic test_random_unsigned();
    int dc, bc, w0, di, dk, dj, ba, bb, bd, exp_cyc;
    longint la [16], lb [16], sum;
    logic exp_ovf;
    for (int it = 0; it < 10; it++) begin
      di = int'($urandom_range(1, 4)); dk = int'($urandom_range(1, 4)); dj = int'($urandom_range(1, 4));
      ba = int'($urandom_range(0, 15)); bb = 64 + int'($urandom_range(0, 15)); bd = 128 + int'($urandom_range(0, 15));
      for (int x = 0; x < 16; x++) begin
        la[x] = (it % 2 == 1) ? longint'($urandom_range(0, 127)) : longint'($urandom_range(0, 65535));
        lb[x] = (it % 2 == 1) ? longint'($urandom_range(0, 127)) : longint'($urandom_range(0, 65535));
        mem0[ba + x] = 16'(la[x]);
        mem0[bb + x] = 16'(lb[x]);
      end
      w0 = wr0;
      op0(8'(di), 8'(dk), 8'(dj), 8'(ba), 8'(bb), 8'(bd), dc, bc);
      exp_ovf = 1'b0;
      for (int r = 0; r < di; r++) begin
        for (int c = 0; c < dj; c++) begin
          sum = 0;
          for (int t = 0; t < dk; t++) sum += la[r * dk + t] * lb[t * dj + c];
          if (sum > 65535) exp_ovf = 1'b1;
          checks++;
          if (mem0[bd + r * dj + c] !== 16'(sum)) begin
            failures++; $display("FAIL rand_u it%0d d[%0d][%0d] got %0d want %0d", it, r, c, mem0[bd + r * dj + c], 16'(sum));
          end
        end
      end
      exp_cyc = di * dj * (3 * dk + 1) + 1;
      checks++; if (dc !== exp_cyc) begin failures++; $display("FAIL rand_u it%0d done got %0d want %0d", it, dc, exp_cyc); end
      checks++; if (ovf0 !== exp_ovf) begin failures++; $display("FAIL rand_u it%0d ovf got %b want %b", it, ovf0, exp_ovf); end
      checks++; if (wr0 - w0 !== di * dj) begin failures++; $display("FAIL rand_u it%0d writes got %0d want %0d", it, wr0 - w0, di * dj); end
    end
  endtask

  task automatic test_random_signed();
    int dc, di, dk, dj, sum;
    int la [9], lb [9];
    logic exp_ovf, o1;
    for (int it = 0; it < 6; it++) begin
      di = int'($urandom_range(1, 3)); dk = int'($urandom_range(1, 3)); dj = int'($urandom_range(1, 3));
      for (int x = 0; x < 9; x++) begin
        la[x] = (it % 2 == 1) ? int'($urandom_range(0, 12)) - 6 : int'($urandom_range(0, 255)) - 128;
        lb[x] = (it % 2 == 1) ? int'($urandom_range(0, 12)) - 6 : int'($urandom_range(0, 255)) - 128;
        mem_s[x]      = 8'(la[x]);
        mem_s[64 + x] = 8'(lb[x]);
      end
      op_s(8'(di), 8'(dk), 8'(dj), 8'h00, 8'h40, 8'h80, dc, o1);
      exp_ovf = 1'b0;
      for (int r = 0; r < di; r++) begin
        for (int c = 0; c < dj; c++) begin
          sum = 0;
          for (int t = 0; t < dk; t++) sum += la[r * dk + t] * lb[t * dj + c];
          if (sum < -128 || sum > 127) exp_ovf = 1'b1;
          checks++;
          if (mem_s[128 + r * dj + c] !== 8'(sum)) begin
            failures++; $display("FAIL rand_s it%0d d[%0d][%0d] got %h want %h", it, r, c, mem_s[128 + r * dj + c], 8'(sum));
          end
        end
      end
      checks++; if (ovf_s !== exp_ovf) begin failures++; $display("FAIL rand_s it%0d ovf got %b want %b", it, ovf_s, exp_ovf); end
    end
  endtask

  initial begin
    for (int x = 0; x < 256; x++) begin
      mem0[x] = '0; mem_s[x] = '0; mem_m[x] = '0;
    end
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    test_reset();
    test_basic();
    test_back_to_back();
    test_empty();
    test_signed();
    test_interleave();
    test_reset_midop();
    test_addr_wrap();
    test_random_unsigned();
    test_random_signed();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
